// File: rtl/comb_sweep_driver.sv
// Walks all 64 {A..F} vectors into comb_ckt, samples {temp,Y5..Y1} at the end of each
// hold window and folds the samples into per-output ones counts plus a 16-bit MISR.
module comb_sweep_driver #(
  parameter int          HOLD_CYCLES = 2,
  parameter logic [15:0] SEED        = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  y,
  input  logic        temp,
  output logic [5:0]  vec,
  output logic        busy,
  output logic        done,
  output logic [34:0] ones_cnt,
  output logic [6:0]  temp_cnt,
  output logic [15:0] sig
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [5:0]       vec_q, vec_d;
  logic [3:0]       hold_q, hold_d;
  logic [4:0][6:0]  ones_q, ones_d;
  logic [6:0]       temp_q, temp_d;
  logic [15:0]      sig_q, sig_d;
  logic             fb;

  // Taps 16,14,13,11 (1-based) of the signature register.
  assign fb = sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10];

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    ones_d  = ones_q;
    temp_d  = temp_q;
    sig_d   = sig_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          vec_d   = '0;
          hold_d  = '0;
          ones_d  = '0;
          temp_d  = '0;
          sig_d   = SEED;
        end
      end
      S_DRIVE: begin
        if (abort) begin
          // Partial counts and signature are deliberately kept for inspection.
          state_d = S_IDLE;
          vec_d   = '0;
          hold_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          for (int i = 0; i < 5; i++) ones_d[i] = ones_q[i] + 7'(y[i]);
          temp_d = temp_q + 7'(temp);
          sig_d  = {sig_q[14:0], fb} ^ {10'b0, temp, y};
          hold_d = '0;
          if (vec_q == 6'd63) state_d = S_DONE;
          else                vec_d   = vec_q + 6'd1;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      ones_q  <= '0;
      temp_q  <= '0;
      sig_q   <= SEED;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      ones_q  <= ones_d;
      temp_q  <= temp_d;
      sig_q   <= sig_d;
    end
  end

  assign vec      = vec_q;
  assign busy     = (state_q == S_DRIVE);
  assign done     = (state_q == S_DONE);
  assign ones_cnt = ones_q;
  assign temp_cnt = temp_q;
  assign sig      = sig_q;

endmodule

// File: tb/tb_comb_sweep_driver.sv
// Bench for comb_sweep_driver: a timeline model of the sweep checked every cycle,
// plus literal expectations for reset values, sweep length and counts.
module tb_comb_sweep_driver;
  localparam int H = 2;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [4:0]  y;
  logic        temp;
  logic [5:0]  vec;
  logic        busy, done;
  logic [34:0] ones_cnt;
  logic [6:0]  temp_cnt;
  logic [15:0] sig;
  int          mode = 0;
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  // Stand-in for comb_ckt: returns {temp,y} for a given vector under a pattern mode.
  function automatic logic [5:0] pat(int md, logic [5:0] v);
    case (md)
      0:       return 6'h00;
      1:       return {v[5], {5{v[0]}}};
      2:       return 6'h3F;
      default: return {v[5] ^ v[0], v[4:0]};
    endcase
  endfunction

  assign {temp, y} = pat(mode, vec);

  comb_sweep_driver #(.HOLD_CYCLES(H), .SEED(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .y(y), .temp(temp),
    .vec(vec), .busy(busy), .done(done), .ones_cnt(ones_cnt),
    .temp_cnt(temp_cnt), .sig(sig)
  );

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: sweep position is simply elapsed drive cycles divided by the hold length.
  bit          m_ok = 0, m_busy = 0, m_done = 0;
  int          m_k = 0, m_temp = 0;
  int          m_ones[5];
  logic [5:0]  m_vec = '0;
  logic [15:0] m_sig = 16'hFFFF;

  function automatic logic [34:0] ones_exp();
    logic [34:0] r;
    for (int i = 0; i < 5; i++) r[7*i +: 7] = 7'(m_ones[i]);
    return r;
  endfunction

  initial forever begin
    logic [5:0] d;
    @(posedge clk);
    if (rst) begin
      m_ok = 1; m_busy = 0; m_done = 0; m_vec = '0; m_temp = 0; m_sig = 16'hFFFF;
      for (int i = 0; i < 5; i++) m_ones[i] = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      if (abort) begin
        m_busy = 0; m_vec = '0;
      end else begin
        if (m_k % H == H - 1) begin
          d = pat(mode, m_vec);
          for (int i = 0; i < 5; i++) m_ones[i] += int'(d[i]);
          m_temp += int'(d[5]);
          m_sig = {m_sig[14:0], ^(m_sig & 16'hB400)} ^ {10'b0, d};
        end
        m_k++;
        if (m_k == 64 * H) begin m_busy = 0; m_done = 1; m_vec = 6'd63; end
        else m_vec = 6'(m_k / H);
      end
    end else if (start) begin
      m_busy = 1; m_k = 0; m_vec = '0; m_temp = 0; m_sig = 16'hFFFF;
      for (int i = 0; i < 5; i++) m_ones[i] = 0;
    end
    @(negedge clk);
    if (m_ok)
      chk("cycle", {vec, busy, done, ones_cnt, temp_cnt, sig},
          {m_vec, m_busy, m_done, ones_exp(), 7'(m_temp), m_sig});
  end

  task automatic check_reset(string nm);
    chk({nm, "_vec"}, 128'(vec), 128'(0));
    chk({nm, "_flags"}, 128'({busy, done}), 128'(0));
    chk({nm, "_cnt"}, 128'({ones_cnt, temp_cnt}), 128'(0));
    chk({nm, "_sig"}, 128'(sig), 128'(16'hFFFF));
  endtask

  task automatic run_sweep(int md, string nm, logic [34:0] exp_ones, logic [6:0] exp_temp);
    int bc, dp;
    mode = md; start = 1'b1;
    @(negedge clk);
    start = 1'b0; bc = 0; dp = 0;
    for (int i = 0; i < 64 * H + 6; i++) begin
      if (busy) bc++;
      if (done) dp++;
      @(negedge clk);
    end
    chk({nm, "_busy_len"}, 128'(bc), 128'(64 * H));
    chk({nm, "_done_pulses"}, 128'(dp), 128'(1));
    chk({nm, "_vec_end"}, 128'(vec), 128'(63));
    chk({nm, "_ones"}, 128'(ones_cnt), 128'(exp_ones));
    chk({nm, "_temp"}, 128'(temp_cnt), 128'(exp_temp));
  endtask

  task automatic wait_vec(logic [5:0] t, string nm);
    for (int i = 0; i < 300 && vec !== t; i++) @(negedge clk);
    chk({nm, "_reach"}, 128'(vec), 128'(t));
  endtask

  initial begin
    int dp;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("reset");

    run_sweep(0, "zero", 35'd0, 7'd0);
    run_sweep(1, "alt", {5{7'd32}}, 7'd32);
    run_sweep(2, "ones", {5{7'd64}}, 7'd64);

    // Abort mid-sweep (start asserted alongside: abort must win).
    mode = 3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_vec(6'd20, "abort");
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_vec", 128'(vec), 128'(0));
    dp = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) dp++;
      @(negedge clk);
    end
    chk("abort_no_done", 128'(dp), 128'(0));
    run_sweep(3, "restart", {5{7'd32}}, 7'd32);

    // Start pulses while busy must not disturb the sweep; then reset mid-sweep.
    mode = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      start = (i % 7 == 3);
      @(negedge clk);
    end
    start = 1'b0;
    wait_vec(6'd40, "midrst");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("midrst");
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
